// File: rtl/multicycle_control.sv
// Main controller for a multi-cycle MIPS datapath: a Moore FSM that drives the
// shared memory, IR, ALU operand muxes and register file. It handles R-type,
// lw, sw, beq, addi and j, stalls on memory wait states, counts retired
// instructions and raises a sticky flag on illegal opcodes.
module multicycle_control #(
  parameter int unsigned CNT_W        = 32,
  parameter bit          ILLEGAL_HALT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUop,
  output logic [1:0]       PCSrc,
  output logic [3:0]       state,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_SEXT  = 2'b10;
  localparam logic [1:0] SRCB_SEXT2 = 2'b11;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_SUB    = 2'b01;
  localparam logic [1:0] ALU_FUNCT  = 2'b10;

  localparam logic [1:0] PC_ALU     = 2'b00;
  localparam logic [1:0] PC_ALUOUT  = 2'b01;
  localparam logic [1:0] PC_JUMP    = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_HALT   = 4'd12
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   retire_c;
  logic   illegal_c;

  // zero gates the PC load in the datapath; the Moore outputs never depend on it.
  logic   unused_zero;
  assign unused_zero = zero;

  // State register, sticky illegal flag and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_FETCH;
      illegal     <= 1'b0;
      instr_count <= '0;
    end else begin
      state_q <= state_d;
      if (illegal_c) begin
        illegal <= 1'b1;
      end
      if (retire_c) begin
        instr_count <= instr_count + CNT_W'(1);
      end
    end
  end

  // Next-state and Moore control decode; everything is held low during reset.
  always_comb begin
    state_d     = state_q;
    retire_c    = 1'b0;
    illegal_c   = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_B;
    ALUop       = ALU_ADD;
    PCSrc       = PC_ALU;

    case (state_q)
      S_FETCH: begin
        // Strobes stay asserted while memory holds off; IR/PC load on completion.
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        if (mem_ready) begin
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        // Speculatively compute the branch target into ALUOut.
        ALUSrcB = SRCB_SEXT2;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default: begin
            illegal_c = 1'b1;
            state_d   = ILLEGAL_HALT ? S_HALT : S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_SEXT;
        if (opcode == OP_LW) begin
          state_d = S_MEMRD;
        end else if (opcode == OP_SW) begin
          state_d = S_MEMWR;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) begin
          state_d = S_MEMWB;
        end
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        retire_c = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        // The store retires on the cycle the memory accepts it.
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (mem_ready) begin
          retire_c = 1'b1;
          state_d  = S_FETCH;
        end
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUop   = ALU_FUNCT;
        state_d = S_RWB;
      end
      S_RWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        retire_c = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUop       = ALU_SUB;
        PCWriteCond = 1'b1;
        PCSrc       = PC_ALUOUT;
        retire_c    = 1'b1;
        state_d     = S_FETCH;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_SEXT;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        RegWrite = 1'b1;
        retire_c = 1'b1;
        state_d  = S_FETCH;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSrc    = PC_JUMP;
        retire_c = 1'b1;
        state_d  = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        // Unreachable encodings recover to instruction fetch.
        state_d = S_FETCH;
      end
    endcase

    if (rst) begin
      retire_c    = 1'b0;
      illegal_c   = 1'b0;
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemtoReg    = 1'b0;
      RegDst      = 1'b0;
      RegWrite    = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = SRCB_B;
      ALUop       = ALU_ADD;
      PCSrc       = PC_ALU;
    end
  end

  assign state = 4'(state_q);

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: a per-cycle vector table for the main
// instruction sequences plus hand-written illegal/wrap/reset corner sequences.
module tb_multicycle_control;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;

  logic        a_pcw, a_pcwc, a_iord, a_mrd, a_mwr, a_irw, a_m2r, a_rdst, a_rw, a_srca;
  logic [1:0]  a_srcb, a_aluop, a_pcsrc;
  logic [3:0]  a_state;
  logic        a_illegal;
  logic [31:0] a_count;

  logic        b_pcw, b_pcwc, b_iord, b_mrd, b_mwr, b_irw, b_m2r, b_rdst, b_rw, b_srca;
  logic [1:0]  b_srcb, b_aluop, b_pcsrc;
  logic [3:0]  b_state;
  logic        b_illegal;
  logic [3:0]  b_count;

  multicycle_control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(a_pcw), .PCWriteCond(a_pcwc), .IorD(a_iord), .MemRead(a_mrd),
    .MemWrite(a_mwr), .IRWrite(a_irw), .MemtoReg(a_m2r), .RegDst(a_rdst),
    .RegWrite(a_rw), .ALUSrcA(a_srca), .ALUSrcB(a_srcb), .ALUop(a_aluop),
    .PCSrc(a_pcsrc), .state(a_state), .illegal(a_illegal), .instr_count(a_count)
  );

  multicycle_control #(.CNT_W(4), .ILLEGAL_HALT(1'b0)) dut4 (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(b_pcw), .PCWriteCond(b_pcwc), .IorD(b_iord), .MemRead(b_mrd),
    .MemWrite(b_mwr), .IRWrite(b_irw), .MemtoReg(b_m2r), .RegDst(b_rdst),
    .RegWrite(b_rw), .ALUSrcA(b_srca), .ALUSrcB(b_srcb), .ALUop(b_aluop),
    .PCSrc(b_pcsrc), .state(b_state), .illegal(b_illegal), .instr_count(b_count)
  );

  // Control word: PCWrite PCWriteCond IorD MemRead MemWrite IRWrite MemtoReg RegDst RegWrite ALUSrcA ALUSrcB ALUop PCSrc
  logic [15:0] a_ctl, b_ctl;
  assign a_ctl = {a_pcw, a_pcwc, a_iord, a_mrd, a_mwr, a_irw, a_m2r, a_rdst, a_rw, a_srca, a_srcb, a_aluop, a_pcsrc};
  assign b_ctl = {b_pcw, b_pcwc, b_iord, b_mrd, b_mwr, b_irw, b_m2r, b_rdst, b_rw, b_srca, b_srcb, b_aluop, b_pcsrc};

  localparam logic [15:0] C_FETCH  = {1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00};
  localparam logic [15:0] C_FETCHW = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00};
  localparam logic [15:0] C_DECODE = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00};
  localparam logic [15:0] C_MEMADR = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00};
  localparam logic [15:0] C_MEMRD  = {1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00};
  localparam logic [15:0] C_MEMWB  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00};
  localparam logic [15:0] C_MEMWR  = {1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00};
  localparam logic [15:0] C_EXEC   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b10,2'b00};
  localparam logic [15:0] C_RWB    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,2'b00};
  localparam logic [15:0] C_BRANCH = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,2'b01};
  localparam logic [15:0] C_ADDIEX = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00};
  localparam logic [15:0] C_ADDIWB = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00};
  localparam logic [15:0] C_JUMP   = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b10};

  typedef struct {
    logic [5:0]  op;
    logic        z;
    logic        mr;
    logic [3:0]  st;
    logic [15:0] ctl;
    logic [31:0] cnt;
  } vec_t;

  localparam int NV = 30;
  vec_t vecs [NV];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // One row per clock: inputs for the cycle and the outputs expected in it.
    vecs[0]  = '{6'h00, 1'b0, 1'b1, 4'd0,  C_FETCH,  32'd0};
    vecs[1]  = '{6'h00, 1'b0, 1'b1, 4'd1,  C_DECODE, 32'd0};
    vecs[2]  = '{6'h00, 1'b0, 1'b1, 4'd6,  C_EXEC,   32'd0};
    vecs[3]  = '{6'h00, 1'b0, 1'b1, 4'd7,  C_RWB,    32'd0};
    vecs[4]  = '{6'h23, 1'b0, 1'b1, 4'd0,  C_FETCH,  32'd1};
    vecs[5]  = '{6'h23, 1'b0, 1'b1, 4'd1,  C_DECODE, 32'd1};
    vecs[6]  = '{6'h23, 1'b0, 1'b1, 4'd2,  C_MEMADR, 32'd1};
    vecs[7]  = '{6'h23, 1'b0, 1'b0, 4'd3,  C_MEMRD,  32'd1};
    vecs[8]  = '{6'h23, 1'b0, 1'b0, 4'd3,  C_MEMRD,  32'd1};
    vecs[9]  = '{6'h23, 1'b0, 1'b1, 4'd3,  C_MEMRD,  32'd1};
    vecs[10] = '{6'h23, 1'b0, 1'b1, 4'd4,  C_MEMWB,  32'd1};
    vecs[11] = '{6'h2B, 1'b0, 1'b0, 4'd0,  C_FETCHW, 32'd2};
    vecs[12] = '{6'h2B, 1'b0, 1'b1, 4'd0,  C_FETCH,  32'd2};
    vecs[13] = '{6'h2B, 1'b0, 1'b1, 4'd1,  C_DECODE, 32'd2};
    vecs[14] = '{6'h2B, 1'b0, 1'b1, 4'd2,  C_MEMADR, 32'd2};
    vecs[15] = '{6'h2B, 1'b0, 1'b1, 4'd5,  C_MEMWR,  32'd2};
    vecs[16] = '{6'h04, 1'b1, 1'b1, 4'd0,  C_FETCH,  32'd3};
    vecs[17] = '{6'h04, 1'b1, 1'b1, 4'd1,  C_DECODE, 32'd3};
    vecs[18] = '{6'h04, 1'b1, 1'b1, 4'd8,  C_BRANCH, 32'd3};
    vecs[19] = '{6'h04, 1'b0, 1'b1, 4'd0,  C_FETCH,  32'd4};
    vecs[20] = '{6'h04, 1'b0, 1'b1, 4'd1,  C_DECODE, 32'd4};
    vecs[21] = '{6'h04, 1'b0, 1'b1, 4'd8,  C_BRANCH, 32'd4};
    vecs[22] = '{6'h08, 1'b0, 1'b1, 4'd0,  C_FETCH,  32'd5};
    vecs[23] = '{6'h08, 1'b0, 1'b1, 4'd1,  C_DECODE, 32'd5};
    vecs[24] = '{6'h08, 1'b0, 1'b1, 4'd9,  C_ADDIEX, 32'd5};
    vecs[25] = '{6'h08, 1'b0, 1'b1, 4'd10, C_ADDIWB, 32'd5};
    vecs[26] = '{6'h02, 1'b0, 1'b1, 4'd0,  C_FETCH,  32'd6};
    vecs[27] = '{6'h02, 1'b0, 1'b1, 4'd1,  C_DECODE, 32'd6};
    vecs[28] = '{6'h02, 1'b0, 1'b1, 4'd11, C_JUMP,   32'd6};
    vecs[29] = '{6'h3F, 1'b0, 1'b1, 4'd0,  C_FETCH,  32'd7};

    rst = 1'b1; opcode = 6'h00; zero = 1'b0; mem_ready = 1'b1;
    cyc();
    cyc();
    // Reset state, with controls forced low even though FETCH would strobe.
    check("reset_state", 32'(a_state), 32'd0);
    check("reset_illegal", 32'(a_illegal), 32'd0);
    check("reset_count", a_count, 32'd0);
    check("reset_ctl_forced", 32'(a_ctl), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      opcode = vecs[i].op; zero = vecs[i].z; mem_ready = vecs[i].mr;
      #1;
      check($sformatf("vec%0d_state", i), 32'(a_state), 32'(vecs[i].st));
      check($sformatf("vec%0d_ctl", i), 32'(a_ctl), 32'(vecs[i].ctl));
      check($sformatf("vec%0d_count", i), a_count, vecs[i].cnt);
      check($sformatf("vec%0d_state4", i), 32'(b_state), 32'(vecs[i].st));
      cyc();
    end

    // Illegal opcode: halting instance sticks in HALT, refetching instance loops.
    opcode = 6'h3F; mem_ready = 1'b1;
    #1;
    check("ill_decode", 32'(a_state), 32'd1);
    cyc();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("ill_halt%0d", k), 32'(a_state), 32'd12);
      check($sformatf("ill_flag%0d", k), 32'(a_illegal), 32'd1);
      check($sformatf("ill_ctl%0d", k), 32'(a_ctl), 32'd0);
      check($sformatf("ill_count%0d", k), a_count, 32'd7);
      check($sformatf("ill_flag4_%0d", k), 32'(b_illegal), 32'd1);
      check($sformatf("ill_count4_%0d", k), 32'(b_count), 32'd7);
      check($sformatf("ill_state4_%0d", k), 32'(b_state), (k % 2 == 0) ? 32'd0 : 32'd1);
      cyc();
    end
    check("ill_state4_fetch", 32'(b_state), 32'd0);
    rst = 1'b1;
    #1;
    check("rst_forced_ctl4", 32'(b_ctl), 32'd0);
    cyc();
    rst = 1'b0;
    check("ill_rst_state", 32'(a_state), 32'd0);
    check("ill_rst_flag", 32'(a_illegal), 32'd0);
    check("ill_rst_count", a_count, 32'd0);
    check("ill_rst_flag4", 32'(b_illegal), 32'd0);

    // Counter wrap on the 4-bit instance: 16 jumps of 3 cycles each.
    opcode = 6'h02; mem_ready = 1'b1;
    repeat (45) cyc();
    check("wrap_pre_count4", 32'(b_count), 32'd15);
    check("wrap_pre_count", a_count, 32'd15);
    check("wrap_pre_state", 32'(a_state), 32'd0);
    repeat (3) cyc();
    check("wrap_count4", 32'(b_count), 32'd0);
    check("wrap_count", a_count, 32'd16);

    // Reset while a store is stalled: aborts without retiring or writing again.
    opcode = 6'h2B;
    cyc();
    cyc();
    mem_ready = 1'b0;
    cyc();
    check("sw_memwr_state", 32'(a_state), 32'd5);
    check("sw_memwr_strobe", 32'(a_mwr), 32'd1);
    cyc();
    check("sw_stall_state", 32'(a_state), 32'd5);
    check("sw_stall_count", a_count, 32'd16);
    rst = 1'b1;
    #1;
    check("sw_rst_strobe", 32'(a_mwr), 32'd0);
    cyc();
    rst = 1'b0;
    check("sw_rst_state", 32'(a_state), 32'd0);
    check("sw_rst_count", a_count, 32'd0);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("sw_post_strobe%0d", k), 32'(a_mwr), 32'd0);
      check($sformatf("sw_post_state%0d", k), 32'(a_state), 32'd0);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
